fa_bist: RTL

- Hardware self-test engine for the team's full-adder implementations (dataflow, behavioural, case-based).
- Drives the shared {ci, a, b} inputs through all 8 combinations, samples the s/co outputs of three DUT instances after a settle window, and compares them against a built-in golden model.
- Reports mismatch count, a per-vector failure map and a pass flag.
- Sits beside the three adder instances as the synthesizable counterpart of the simulation stimulus/display bench.

---
 rtl/fa_bist.sv | 101 ++++++++++
 1 files changed

// File: rtl/fa_bist.sv
// Self-test engine for three full-adder instances on shared inputs.
// Sweeps all eight {ci,a,b} vectors and scores each DUT against a golden adder.
module fa_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] s_in,
  input  logic [2:0] co_in,
  output logic       a,
  output logic       b,
  output logic       ci,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [7:0] fail_vec
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] APPLY = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] SLAST =
    (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  logic [2:0] state;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       exp_s;
  logic       exp_co;
  logic [2:0] mm;
  logic [1:0] mm_cnt;

  // Operands come straight from the vector register, so they never glitch.
  assign b  = vec[0];
  assign a  = vec[1];
  assign ci = vec[2];

  assign busy = (state == APPLY) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 5'd0);

  always_comb begin
    exp_s  = ^vec;
    exp_co = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
    for (int i = 0; i < 3; i++) begin
      mm[i] = (s_in[i] != exp_s) | (co_in[i] != exp_co);
    end
    mm_cnt = {1'b0, mm[0]} + {1'b0, mm[1]} + {1'b0, mm[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= 3'd0;
      cnt      <= 4'd0;
      err_cnt  <= 5'd0;
      fail_vec <= 8'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            err_cnt  <= 5'd0;
            fail_vec <= 8'd0;
            vec      <= 3'd0;
            state    <= APPLY;
          end
        end
        APPLY: begin
          cnt   <= 4'd0;
          state <= (SETTLE == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (cnt == SLAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CHECK: begin
          err_cnt <= err_cnt + {3'd0, mm_cnt};
          if (|mm) begin
            fail_vec[vec] <= 1'b1;
          end
          if (vec == 3'd7) begin
            state <= DONE;
          end else begin
            vec   <= vec + 3'd1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
